// File: rtl/serial_add_ctrl_pkg.sv
// Shared types and limits for the bit-serial add/subtract engine.
// Provides the FSM state encoding and the legal WIDTH range.
package serial_add_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 64;

endpackage

// File: rtl/fa.sv
// One-bit full-adder cell.
// Ports: a, b, ci in; s = a^b^ci, co = majority(a,b,ci) out.
module fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract engine: one full-adder cell, LSB first.
// Ports: clk, rst, start, sub, a, b, cin in; busy, done, sum, cout, overflow out.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  import serial_add_ctrl_pkg::*;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_MSB  = CW'(WIDTH - 2);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("serial_add_ctrl: WIDTH out of range");
  end

  state_t state, state_nx;
  logic   accept;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             c_msb_in;
  logic             fa_s;
  logic             fa_co;
  logic             last;

  assign last = (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (last) state_nx = DONE;
      end
      DONE: begin
        accept   = start;
        state_nx = start ? RUN : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  fa u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh     <= '0;
      b_sh     <= '0;
      res_sh   <= '0;
      cnt      <= '0;
      carry    <= 1'b0;
      c_msb_in <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= sub ? ~b : b;
      carry <= sub | cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
      b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
      res_sh <= {fa_s, res_sh[WIDTH-1:1]};
      carry  <= fa_co;
      if (!last) cnt <= cnt + 1'b1;
      // carry out of bit WIDTH-2 is the carry into the MSB
      if (cnt == CNT_MSB) c_msb_in <= fa_co;
      if (last) begin
        sum      <= {fa_s, res_sh[WIDTH-1:1]};
        cout     <= fa_co;
        overflow <= c_msb_in ^ fa_co;
      end
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Randomized self-checking bench for serial_add_ctrl (WIDTH=8).
// Reference model uses plain integer arithmetic.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;

  int n_vec;
  int n_bad;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model(input  logic [W-1:0] ma,
                                input  logic [W-1:0] mb,
                                input  logic         mcin,
                                input  logic         msub,
                                output logic [W-1:0] ms,
                                output logic         mco,
                                output logic         mov);
    int ua, ub, sa, sb, u, r;
    ua = int'(ma);
    ub = int'(mb);
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    if (msub) begin
      u   = ua - ub;
      r   = sa - sb;
      mco = (ua >= ub);
    end else begin
      u   = ua + ub + int'(mcin);
      r   = sa + sb + int'(mcin);
      mco = (u >= (1 << W));
    end
    ms  = W'(u);
    mov = (r > 127) || (r < -128);
  endfunction

  task automatic scramble();
    a   = W'($urandom);
    b   = W'($urandom);
    cin = 1'($urandom);
    sub = 1'($urandom);
  endtask

  // Called at a negedge with the FSM in IDLE or DONE; returns at the
  // negedge after the result edge, start low, FSM in DONE.
  task automatic do_op(input logic [W-1:0] oa,
                       input logic [W-1:0] ob,
                       input logic         oc,
                       input logic         os);
    logic [W-1:0] es;
    logic         eco, eov;
    model(oa, ob, oc, os, es, eco, eov);
    a     = oa;
    b     = ob;
    cin   = oc;
    sub   = os;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    scramble();
    for (int k = 1; k <= W; k++) begin
      @(negedge clk);
      check("busy_run", 64'(busy), 64'd1);
      check("done_run", 64'(done), 64'd0);
      start = 1'($urandom);
      scramble();
    end
    @(negedge clk);
    start = 1'b0;
    check("done_pulse", 64'(done), 64'd1);
    check("busy_done", 64'(busy), 64'd0);
    check("sum", 64'(sum), 64'(es));
    check("cout", 64'(cout), 64'(eco));
    check("ovf", 64'(overflow), 64'(eov));
  endtask

  task automatic idle_hold(input int cycles);
    logic [W-1:0] hs;
    logic         hc, ho;
    hs = sum;
    hc = cout;
    ho = overflow;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      scramble();
      check("idle_done", 64'(done), 64'd0);
      check("idle_busy", 64'(busy), 64'd0);
      check("hold_sum", 64'(sum), 64'(hs));
      check("hold_cout", 64'(cout), 64'(hc));
      check("hold_ovf", 64'(overflow), 64'(ho));
    end
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst   = 1'b1;
    start = 1'b0;
    sub   = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    #2;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_cout", 64'(cout), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    do_op(8'h5A, 8'h33, 1'b0, 1'b0);
    idle_hold(2);
    do_op(8'hFF, 8'h01, 1'b0, 1'b0);
    do_op(8'h00, 8'h00, 1'b1, 1'b0);
    do_op(8'h10, 8'h20, 1'b1, 1'b1);
    do_op(8'h80, 8'h01, 1'b0, 1'b1);
    do_op(8'h7F, 8'h01, 1'b0, 1'b0);
    idle_hold(6);

    // asynchronous reset in the 4th RUN cycle
    a     = 8'hC3;
    b     = 8'h5F;
    cin   = 1'b1;
    sub   = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_sum", 64'(sum), 64'd0);
    check("arst_cout", 64'(cout), 64'd0);
    check("arst_ovf", 64'(overflow), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_op(8'h01, 8'h01, 1'b0, 1'b0);
    idle_hold(3);

    // random ops, mostly back-to-back with occasional idle gaps
    for (int i = 0; i < 40; i++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) idle_hold(int'($urandom_range(1, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial add/subtract engine that runs a single one-bit full-adder cell over a WIDTH-bit operand pair, one bit per clock, LSB first.
- Provides a start/busy/done handshake, a registered carry chain, and signed-overflow detection.
- Lets the arithmetic path trade area for latency: one adder cell instead of WIDTH cells.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..64.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a new operation; sampled only in IDLE or DONE.
- sub  input  1  0 = A+B+cin; 1 = A-B, i.e. A + ~B + 1, with cin ignored.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- cin  input  1  carry-in for add mode; captured on the accepting edge.
- busy  output  1  high while bits are being processed (state RUN).
- done  output  1  one-cycle pulse; result valid (state DONE).
- sum  output  WIDTH  result; registered, held stable until the next result is written.
- cout  output  1  carry out of the MSB; in sub mode, 1 = no borrow.
- overflow  output  1  signed overflow = carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, done=0, sum=0, cout=0, overflow=0; all internal shift registers, carry register and counter cleared. A reset mid-operation discards the operation with no partial result.
- FSM states: IDLE, RUN, DONE.
- IDLE/DONE with start=1 at an edge (E0), the accept step:
  - load a_sh=a and b_sh = sub ? ~b : b;
  - carry = sub ? 1 : cin;
  - cnt=0; state -> RUN.
- IDLE with start=0: stay in IDLE.
- DONE with start=0: go to IDLE.
- RUN, each edge:
  - full-adder cell inputs a_sh[0], b_sh[0], carry;
  - the sum bit shifts into res_sh at the MSB end while res_sh shifts right;
  - a_sh and b_sh shift right; carry takes the cell's carry output; cnt increments.
  - When cnt==WIDTH-2 at an edge, latch the current cell carry-out into c_msb_in (carry into the MSB).
  - When cnt==WIDTH-1 at an edge (edge E_WIDTH), write sum = final res_sh including this bit, cout = cell carry-out, and overflow = c_msb_in XOR cell carry-out; state -> DONE.
- Latency: done is high in the cycle after edge E_WIDTH, exactly WIDTH+1 edges after acceptance counting E0.
- Throughput: one operation per WIDTH+1 cycles when start is held high (DONE -> RUN directly).
- busy = (state==RUN); done = (state==DONE). Both are decoded from registered state, so there is no combinational path from inputs.
- start in RUN is ignored; no queuing.
- a, b, cin, sub are don't-care except on the accepting edge.
- sum/cout/overflow change only on the edge that enters DONE and otherwise hold their last value.
- cnt width is $clog2(WIDTH); it never wraps within an operation.

Decomposition:
- Shared package: state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the WIDTH bounds constant.
- One sub-module: the existing one-bit full-adder cell `fa`, instantiated once in the RUN datapath; no other hierarchy.

Test Plan (WIDTH=8):
- Add, a=0x5A, b=0x33, cin=0, start pulse -> busy high 8 cycles, done pulse at cycle 9; sum=0x8D, cout=0, overflow=1.
- Add, a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, overflow=0. Then a=0x00, b=0x00, cin=1 -> sum=0x01, cout=0.
- Sub, a=0x10, b=0x20 -> sum=0xF0, cout=0 (borrow), overflow=0. Sub, a=0x80, b=0x01 -> sum=0x7F, cout=1, overflow=1.
- Start held high continuously with changing operands -> each result appears every 9 cycles. Start pulses during RUN are ignored: the result matches operands from the accepting edge only.
- rst asserted asynchronously during the 4th RUN cycle -> busy, done, sum, cout, overflow = 0 immediately. After release, a fresh start of 0x01+0x01 gives sum=0x02 at cycle 9.
- No start after DONE -> FSM returns to IDLE; sum/cout/overflow hold their values indefinitely; done stays 0.
